// File: rtl/i2c_eeprom_slave_if.sv
// Pin-level bundle between an I2C bus driver and the EEPROM slave.
// SDA is open drain: the slave only ever reports whether it pulls the line low.
interface i2c_eeprom_slave_if;
  logic       scl_i;
  logic       sda_i;
  logic       sda_oe;
  logic       wp;
  logic [2:0] a_pins;
  logic       busy;

  modport slave  (input scl_i, sda_i, wp, a_pins, output sda_oe, busy);
  modport master (output scl_i, sda_i, wp, a_pins, input sda_oe, busy);
endinterface

// File: rtl/i2c_eeprom_slave.sv
// AT24Cxx-style I2C EEPROM slave.
// SCL/SDA are oversampled on clk. Writes collect in a page buffer that is flushed
// to the array after a STOP, during a busy window in which the device address is NACKed.
module i2c_eeprom_slave #(
  parameter int         MEM_BYTES  = 256,
  parameter int         ADDR_BYTES = 1,
  parameter int         PAGE_BYTES = 8,
  parameter logic [3:0] DEV_TYPE   = 4'b1010,
  parameter int         WR_CYCLES  = 1000
) (
  input logic               clk,
  input logic               reset_n,
  i2c_eeprom_slave_if.slave bus
);
  localparam int AW          = $clog2(MEM_BYTES);
  localparam int PW          = $clog2(PAGE_BYTES);
  localparam int BUSY_CYCLES = PAGE_BYTES + WR_CYCLES;
  localparam int BCW         = $clog2(BUSY_CYCLES + 1);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_BYTES - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV, ST_ACK_DEV, ST_WADDR, ST_ACK_WADDR,
    ST_WR, ST_ACK_WR, ST_RD, ST_RD_ACK
  } state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  state_t          state;
  logic [3:0]      bit_cnt;
  logic [7:0]      shift;
  logic [AW-1:0]   addr;
  logic [1:0]      abyte_cnt;
  logic            rw_bit;
  logic            master_ack;
  logic            sda_oe_q;
  logic            busy_q;
  logic [BCW-1:0]  busy_cnt;
  logic            commit_on;
  logic [PW-1:0]   commit_idx;
  logic [AW-1:0]   page_base;
  logic [7:0]      page_data [PAGE_BYTES];
  logic [PAGE_BYTES-1:0] page_valid;
  logic [7:0]      mem [MEM_BYTES];

  logic          scl_rise, scl_fall, start_det, stop_det;
  logic          dev_match, rx_state, mem_we;
  logic [AW-1:0] addr_loaded, addr_page_inc, mem_waddr;
  logic [7:0]    rd_byte;

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;

  assign dev_match     = (shift[7:1] == {DEV_TYPE, bus.a_pins}) && !busy_q;
  assign rx_state      = (state == ST_DEV) || (state == ST_WADDR) || (state == ST_WR);
  assign addr_loaded   = AW'({addr, shift});
  assign addr_page_inc = (addr & ~PAGE_MASK) | ((addr + ONE) & PAGE_MASK);
  assign rd_byte       = mem[addr];
  assign mem_waddr     = page_base | AW'(commit_idx);
  assign mem_we        = reset_n && commit_on && page_valid[commit_idx];

  assign bus.sda_oe = sda_oe_q;
  assign bus.busy   = busy_q;

  // Two-stage synchroniser plus one delay stage per pin for edge detection; idles high.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_i; scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= bus.sda_i; sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  // Protocol FSM, page buffer and the post-STOP commit/busy engine.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      addr       <= '0;
      abyte_cnt  <= '0;
      rw_bit     <= 1'b0;
      master_ack <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      busy_cnt   <= '0;
      commit_on  <= 1'b0;
      commit_idx <= '0;
      page_base  <= '0;
      page_valid <= '0;
      for (int i = 0; i < PAGE_BYTES; i++) page_data[i] <= '0;
    end else begin
      if (busy_q) begin
        if (busy_cnt == '0) busy_q <= 1'b0;
        else                busy_cnt <= busy_cnt - BCW'(1);
      end
      if (commit_on) begin
        page_valid[commit_idx] <= 1'b0;
        commit_idx <= commit_idx + PW'(1);
        if (commit_idx == PW'(PAGE_BYTES - 1)) commit_on <= 1'b0;
      end

      if (start_det) begin
        state     <= ST_DEV;
        bit_cnt   <= '0;
        sda_oe_q  <= 1'b0;
        abyte_cnt <= '0;
        if (state == ST_WADDR || state == ST_ACK_WADDR || state == ST_WR || state == ST_ACK_WR)
          page_valid <= '0;
      end else if (stop_det) begin
        state    <= ST_IDLE;
        sda_oe_q <= 1'b0;
        if (state == ST_WR && |page_valid) begin
          busy_q     <= 1'b1;
          busy_cnt   <= BCW'(BUSY_CYCLES - 1);
          commit_on  <= 1'b1;
          commit_idx <= '0;
          page_base  <= addr & ~PAGE_MASK;
        end else if (!busy_q) begin
          page_valid <= '0;
        end
      end else begin
        if (rx_state && scl_rise && bit_cnt != 4'd8) begin
          shift   <= {shift[6:0], sda_s2};
          bit_cnt <= bit_cnt + 4'd1;
        end
        case (state)
          ST_DEV: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              if (dev_match) begin
                sda_oe_q <= 1'b1;
                rw_bit   <= shift[0];
                state    <= ST_ACK_DEV;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          ST_ACK_DEV: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw_bit) begin
                shift    <= rd_byte;
                sda_oe_q <= ~rd_byte[7];
                state    <= ST_RD;
              end else begin
                sda_oe_q  <= 1'b0;
                abyte_cnt <= '0;
                state     <= ST_WADDR;
              end
            end
          end
          ST_WADDR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              addr     <= addr_loaded;
              sda_oe_q <= 1'b1;
              state    <= ST_ACK_WADDR;
            end
          end
          ST_ACK_WADDR: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              if (abyte_cnt == 2'(ADDR_BYTES - 1)) begin
                state <= ST_WR;
              end else begin
                abyte_cnt <= abyte_cnt + 2'd1;
                state     <= ST_WADDR;
              end
            end
          end
          ST_WR: begin
            if (scl_fall && bit_cnt == 4'd8) begin
              state <= ST_ACK_WR;
              if (!bus.wp) begin
                sda_oe_q                <= 1'b1;
                page_data[addr[PW-1:0]]  <= shift;
                page_valid[addr[PW-1:0]] <= 1'b1;
                addr                    <= addr_page_inc;
              end
            end
          end
          ST_ACK_WR: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= '0;
              state    <= ST_WR;
            end
          end
          ST_RD: begin
            if (scl_rise && bit_cnt != 4'd8) bit_cnt <= bit_cnt + 4'd1;
            if (scl_fall) begin
              if (bit_cnt == 4'd8) begin
                sda_oe_q <= 1'b0;
                addr     <= addr + ONE;
                state    <= ST_RD_ACK;
              end else if (bit_cnt != 4'd0) begin
                sda_oe_q <= ~shift[6];
                shift    <= {shift[6:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: begin
            if (scl_rise) begin
              if (sda_s2) state <= ST_IDLE;
              else        master_ack <= 1'b1;
            end
            if (scl_fall && master_ack) begin
              master_ack <= 1'b0;
              shift      <= rd_byte;
              sda_oe_q   <= ~rd_byte[7];
              bit_cnt    <= '0;
              state      <= ST_RD;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Memory array flush from the page buffer, one slot per clk; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= page_data[commit_idx];
  end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Directed-plus-random bench for i2c_eeprom_slave: an I2C master built from tasks drives the
// bus, and a byte-array model of the EEPROM predicts every read and acknowledge.
module tb_i2c_eeprom_slave;
  localparam int MEM_BYTES  = 256;
  localparam int PAGE_BYTES = 8;
  localparam int WR_CYCLES  = 1000;
  localparam int Q          = 50;

  logic clk = 1'b0;
  logic reset_n;
  logic scl_m, sda_m;

  i2c_eeprom_slave_if bus();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_eeprom_slave #(
    .MEM_BYTES(MEM_BYTES), .ADDR_BYTES(1), .PAGE_BYTES(PAGE_BYTES),
    .DEV_TYPE(4'b1010), .WR_CYCLES(WR_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  int passes = 0;
  int fails  = 0;
  int checks = 0;
  int busy_run = 0;
  int busy_len = 0;

  logic [7:0] model_mem [MEM_BYTES];
  bit         model_known [MEM_BYTES];
  int         model_ptr = 0;
  logic [7:0] wr_data [$];

  // Length of the most recent busy pulse, in clk cycles.
  always @(negedge clk) begin
    if (bus.busy === 1'b1) busy_run++;
    else begin
      if (busy_run != 0) busy_len = busy_run;
      busy_run = 0;
    end
  end

  // Hang guard.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] dev_byte(input bit rw);
    return {4'b1010, bus.a_pins, rw};
  endfunction

  // Page write as the device should see it: address wraps inside the page, last write wins.
  function automatic void model_write(input int start, input logic [7:0] d[$]);
    for (int i = 0; i < d.size(); i++) begin
      int a;
      a = (start / PAGE_BYTES) * PAGE_BYTES + ((start + i) % PAGE_BYTES);
      model_mem[a]   = d[i];
      model_known[a] = 1'b1;
    end
  endfunction

  task automatic i2c_start();
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #(2*Q) sda_m = 1'b0;
    #(2*Q) scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    #Q sda_m = 1'b0;
    #Q scl_m = 1'b1;
    #(2*Q) sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic write_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      #Q sda_m = b[i];
      #Q scl_m = 1'b1;
      #(2*Q) scl_m = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic ack);
    #Q sda_m = 1'b1;
    #Q scl_m = 1'b1;
    #Q ack = (bus.sda_i === 1'b0);
    #Q scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    write_bits(b);
    ack_slot(ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input bit give_ack);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      #Q sda_m = 1'b1;
      #Q scl_m = 1'b1;
      #Q b = {b[6:0], bus.sda_i};
      #Q scl_m = 1'b0;
    end
    #Q sda_m = give_ack ? 1'b0 : 1'b1;
    #Q scl_m = 1'b1;
    #(2*Q) scl_m = 1'b0;
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (bus.busy === 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check_output("busy_timeout", 32'(bus.busy), 32'd0);
    @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] waddr, input bit data_acked, input string tag);
    logic ack;
    i2c_start();
    send_byte(dev_byte(1'b0), ack);
    check_output({tag, "_dev_ack"}, 32'(ack), 32'd1);
    send_byte(waddr, ack);
    check_output({tag, "_addr_ack"}, 32'(ack), 32'd1);
    foreach (wr_data[i]) begin
      send_byte(wr_data[i], ack);
      check_output($sformatf("%s_data%0d_ack", tag, i), 32'(ack), 32'(data_acked));
    end
    i2c_stop();
    if (data_acked) model_write(int'(waddr), wr_data);
  endtask

  task automatic do_read(input logic [7:0] waddr, input int n, input string tag);
    logic ack;
    logic [7:0] b;
    int a;
    i2c_start();
    send_byte(dev_byte(1'b0), ack);
    check_output({tag, "_dev_ack"}, 32'(ack), 32'd1);
    send_byte(waddr, ack);
    check_output({tag, "_addr_ack"}, 32'(ack), 32'd1);
    i2c_start();
    send_byte(dev_byte(1'b1), ack);
    check_output({tag, "_devr_ack"}, 32'(ack), 32'd1);
    for (int i = 0; i < n; i++) begin
      read_byte(b, i != n - 1);
      a = (int'(waddr) + i) % MEM_BYTES;
      if (model_known[a]) check_output($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(model_mem[a]));
    end
    i2c_stop();
    model_ptr = (int'(waddr) + n) % MEM_BYTES;
  endtask

  task automatic current_read(input string tag);
    logic ack;
    logic [7:0] b;
    i2c_start();
    send_byte(dev_byte(1'b1), ack);
    check_output({tag, "_devr_ack"}, 32'(ack), 32'd1);
    read_byte(b, 1'b0);
    check_output({tag, "_byte"}, 32'(b), 32'(model_mem[model_ptr]));
    i2c_stop();
    model_ptr = (model_ptr + 1) % MEM_BYTES;
  endtask

  task automatic poll_dev(input bit expect_ack, input string tag);
    logic ack;
    i2c_start();
    send_byte(dev_byte(1'b0), ack);
    check_output(tag, 32'(ack), 32'(expect_ack));
    i2c_stop();
  endtask

  initial begin
    logic ack;
    int   start, len;

    scl_m = 1'b1; sda_m = 1'b1;
    bus.wp = 1'b0; bus.a_pins = 3'b010;
    reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check_output("reset_sda_oe", 32'(bus.sda_oe), 32'd0);
    check_output("reset_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("[TB] byte write then random read");
    wr_data = '{8'h5A};
    do_write(8'h10, 1'b1, "t1");
    check_output("t1_busy", 32'(bus.busy), 32'd1);
    wait_not_busy();
    check_output("t1_busy_len", 32'(busy_len), 32'(PAGE_BYTES + WR_CYCLES));
    do_read(8'h10, 1, "t1_rd");

    $display("[TB] page 0 fill, then overflowing page write");
    wr_data = {};
    for (int i = 0; i < PAGE_BYTES; i++) wr_data.push_back(8'($urandom_range(0, 255)));
    do_write(8'h00, 1'b1, "fill");
    wait_not_busy();
    wr_data = {};
    for (int i = 0; i < 10; i++) wr_data.push_back(8'(i));
    do_write(8'h06, 1'b1, "t2");
    wait_not_busy();
    do_read(8'h00, PAGE_BYTES, "t2_rd");

    $display("[TB] ACK polling");
    wr_data = '{8'($urandom_range(0, 255))};
    do_write(8'h20, 1'b1, "t3");
    poll_dev(1'b0, "t3_poll_busy");
    wait_not_busy();
    poll_dev(1'b1, "t3_poll_done");

    $display("[TB] write protect");
    bus.wp = 1'b1;
    wr_data = '{8'h33};
    do_write(8'h20, 1'b0, "t4");
    check_output("t4_busy", 32'(bus.busy), 32'd0);
    bus.wp = 1'b0;
    do_read(8'h20, 1, "t4_rd");

    $display("[TB] sequential read across the top of memory");
    wr_data = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    do_write(8'hFE, 1'b1, "t5w");
    wait_not_busy();
    do_read(8'hFE, 4, "t5_rd");
    current_read("t5_cur");

    $display("[TB] address pin matching");
    i2c_start();
    send_byte(8'hA0, ack);
    check_output("mismatch_ack", 32'(ack), 32'd0);
    i2c_stop();
    bus.a_pins = 3'b000;
    poll_dev(1'b1, "pins000_ack");
    bus.a_pins = 3'b010;

    $display("[TB] random page writes");
    for (int r = 0; r < 3; r++) begin
      start = int'($urandom_range(0, 255));
      len   = int'($urandom_range(1, 12));
      wr_data = {};
      for (int i = 0; i < len; i++) wr_data.push_back(8'($urandom_range(0, 255)));
      do_write(8'(start), 1'b1, $sformatf("rnd%0d", r));
      wait_not_busy();
      do_read(8'((start / PAGE_BYTES) * PAGE_BYTES), PAGE_BYTES, $sformatf("rnd%0d_rd", r));
    end

    $display("[TB] reset in the middle of a page write");
    i2c_start();
    send_byte(dev_byte(1'b0), ack);
    check_output("t6_dev_ack", 32'(ack), 32'd1);
    send_byte(8'h10, ack);
    send_byte(8'hC3, ack);
    write_bits(8'h3C);
    #(2*Q);
    check_output("t6_ack_driven", 32'(bus.sda_oe), 32'd1);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("t6_sda_oe", 32'(bus.sda_oe), 32'd0);
    check_output("t6_busy", 32'(bus.busy), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    do_read(8'h10, 2, "t6_rd");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
